// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port round-robin arbiter.
package fifo_wr_arbiter_pkg;

    // Arbiter FSM states: waiting for a request, or holding a grant for a burst.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after last_id, with wrap.
module rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last_id,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [ID_WIDTH-1:0] idx,
    output logic                any_req
);

    // Scan offsets from farthest to nearest so the nearest requester after last_id wins.
    always_comb begin
        int k;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        gnt     = '0;
        idx     = '0;
        any_req = |req;
        k       = 0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            k = (int'(last_id) + off) % NUM_REQ;
            if (req[k]) begin
                gnt    = '0;
                gnt[k] = 1'b1;
                idx    = ID_WIDTH'(k);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between NUM_REQ requesters.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_BURST    = 4,
    parameter int IDLE_TIMEOUT = 8,
    parameter int ID_WIDTH     = id_width(NUM_REQ),
    parameter int BCNT_WIDTH   = $clog2(MAX_BURST + 1),
    parameter int TCNT_WIDTH   = $clog2(IDLE_TIMEOUT + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_vld_i,
    output logic [NUM_REQ-1:0]            req_rdy_o,
    input  logic [NUM_REQ-1:0]            req_last_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic                          fifo_wr_vld_o,
    input  logic                          fifo_wr_rdy_i,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
    output logic [ID_WIDTH-1:0]           fifo_wr_id_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o
);

    state_e                state, state_nxt;
    logic [ID_WIDTH-1:0]   g_idx;
    logic [ID_WIDTH-1:0]   last_id;
    logic [NUM_REQ-1:0]    grant_q;
    logic [BCNT_WIDTH-1:0] burst_cnt;
    logic [TCNT_WIDTH-1:0] tmo_cnt;

    logic [NUM_REQ-1:0]    pick_gnt;
    logic [ID_WIDTH-1:0]   pick_idx;
    logic                  any_req;

    logic                  locked;
    logic                  g_vld;
    logic                  g_last;
    logic                  beat;
    logic                  burst_done;
    logic                  timed_out;
    logic                  rel;

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req     (req_vld_i),
        .last_id (last_id),
        .gnt     (pick_gnt),
        .idx     (pick_idx),
        .any_req (any_req)
    );

    assign locked     = (state == ST_LOCKED);
    assign g_vld      = req_vld_i[g_idx];
    assign g_last     = req_last_i[g_idx];
    assign beat       = locked && g_vld && fifo_wr_rdy_i;
    assign burst_done = g_last || (burst_cnt == BCNT_WIDTH'(MAX_BURST - 1));
    assign timed_out  = !g_vld && (tmo_cnt == TCNT_WIDTH'(IDLE_TIMEOUT - 1));
    assign rel        = locked && ((beat && burst_done) || timed_out);
    assign grant_o    = grant_q;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state: lock on any request, release on last beat, full burst or idle timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (any_req) state_nxt = ST_LOCKED;
            ST_LOCKED: if (rel)     state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: FIFO port follows the granted requester while locked, quiet otherwise.
    always_comb begin
        fifo_wr_vld_o  = 1'b0;
        fifo_wr_data_o = '0;
        fifo_wr_id_o   = '0;
        req_rdy_o      = '0;
        busy_o         = locked;
        if (locked) begin
            fifo_wr_vld_o    = g_vld;
            fifo_wr_data_o   = req_data_i[int'(g_idx)*DATA_WIDTH +: DATA_WIDTH];
            fifo_wr_id_o     = g_idx;
            req_rdy_o[g_idx] = fifo_wr_rdy_i;
        end
    end

    // Grant, round-robin pointer, burst and timeout counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grant_q   <= '0;
            g_idx     <= '0;
            last_id   <= ID_WIDTH'(NUM_REQ - 1);
            burst_cnt <= '0;
            tmo_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_q <= pick_gnt;
                        g_idx   <= pick_idx;
                    end
                end
                ST_LOCKED: begin
                    if (rel) begin
                        grant_q   <= '0;
                        last_id   <= g_idx;
                        burst_cnt <= '0;
                        tmo_cnt   <= '0;
                    end else begin
                        if (beat)  burst_cnt <= burst_cnt + BCNT_WIDTH'(1);
                        if (g_vld) tmo_cnt   <= '0;
                        else       tmo_cnt   <= tmo_cnt + TCNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic vs a model.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int DW           = 32;
    localparam int MAX_BURST    = 4;
    localparam int IDLE_TIMEOUT = 8;
    localparam int ID_WIDTH     = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_vld;
    logic [NUM_REQ-1:0]    req_rdy;
    logic [NUM_REQ-1:0]    req_last;
    logic [NUM_REQ*DW-1:0] req_data;
    logic                  fifo_wr_vld;
    logic                  fifo_wr_rdy;
    logic [DW-1:0]         fifo_wr_data;
    logic [ID_WIDTH-1:0]   fifo_wr_id;
    logic [NUM_REQ-1:0]    grant;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    // Reference model state: plain integers, beats counted from 1.
    bit                 m_locked;
    int                 m_g;
    int                 m_beats;
    int                 m_idle;
    int                 m_last;
    logic               exp_busy;
    logic               exp_vld;
    logic [NUM_REQ-1:0] exp_grant;
    logic [NUM_REQ-1:0] exp_rdy;
    logic [DW-1:0]      exp_data;

    fifo_wr_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DATA_WIDTH   (DW),
        .MAX_BURST    (MAX_BURST),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_vld_i      (req_vld),
        .req_rdy_o      (req_rdy),
        .req_last_i     (req_last),
        .req_data_i     (req_data),
        .fifo_wr_vld_o  (fifo_wr_vld),
        .fifo_wr_rdy_i  (fifo_wr_rdy),
        .fifo_wr_data_o (fifo_wr_data),
        .fifo_wr_id_o   (fifo_wr_id),
        .grant_o        (grant),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req_vld     = '0;
        req_last    = '0;
        req_data    = '0;
        fifo_wr_rdy = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Expected outputs from the model state and the current inputs.
    task automatic model_eval();
        exp_busy  = m_locked;
        exp_grant = '0;
        exp_rdy   = '0;
        exp_vld   = 1'b0;
        exp_data  = '0;
        if (m_locked) begin
            exp_grant[m_g] = 1'b1;
            exp_vld        = req_vld[m_g];
            exp_data       = req_data[m_g*DW +: DW];
            if (fifo_wr_rdy) exp_rdy[m_g] = 1'b1;
        end
    endtask

    // Advance the model by one clock using the current inputs.
    task automatic model_step();
        bit took;
        bit fin;
        if (!m_locked) begin
            for (int off = NUM_REQ; off >= 1; off--) begin
                if (req_vld[(m_last + off) % NUM_REQ]) m_g = (m_last + off) % NUM_REQ;
            end
            if (req_vld != '0) begin
                m_locked = 1'b1;
                m_beats  = 0;
                m_idle   = 0;
            end
        end else begin
            took = req_vld[m_g] && fifo_wr_rdy;
            if (took) m_beats++;
            m_idle = req_vld[m_g] ? 0 : m_idle + 1;
            fin = (took && (req_last[m_g] || m_beats == MAX_BURST)) || (m_idle == IDLE_TIMEOUT);
            if (fin) begin
                m_locked = 1'b0;
                m_last   = m_g;
                m_beats  = 0;
                m_idle   = 0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        req_vld = '1;
        settle();
        checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (fifo_wr_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", fifo_wr_vld); end
        checks++; if (req_rdy !== '0) begin errors++; $display("FAIL reset_rdy: got %b expected 0000", req_rdy); end
        checks++; if (fifo_wr_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", fifo_wr_data); end
        tick();
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_single();
        logic [DW-1:0] d;
        do_reset();
        req_vld[1] = 1'b1;
        req_data[1*DW +: DW] = 32'hA000_0001;
        settle();
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_latency: got %b expected 0000", grant); end
        tick();
        for (int b = 0; b < 3; b++) begin
            d = 32'hA000_0001 + DW'(b);
            req_data[1*DW +: DW] = d;
            req_last[1] = (b == 2);
            settle();
            checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL single_grant: beat %0d got %b expected 0010", b, grant); end
            checks++; if (fifo_wr_vld !== 1'b1 || fifo_wr_id !== 2'd1) begin errors++; $display("FAIL single_write: beat %0d got vld %b id %0d expected vld 1 id 1", b, fifo_wr_vld, fifo_wr_id); end
            checks++; if (fifo_wr_data !== d) begin errors++; $display("FAIL single_data: beat %0d got %h expected %h", b, fifo_wr_data, d); end
            checks++; if (req_rdy !== 4'b0010) begin errors++; $display("FAIL single_rdy: beat %0d got %b expected 0010", b, req_rdy); end
            tick();
        end
        clear_inputs();
        settle();
        checks++; if (busy !== 1'b0 || grant !== '0) begin errors++; $display("FAIL single_release: got busy %b grant %b expected busy 0 grant 0000", busy, grant); end
    endtask

    task automatic test_fairness();
        int k;
        do_reset();
        req_vld = '1;
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DW +: DW] = 32'hF000_0000 | DW'(i << 8);
        for (int r = 0; r < 5; r++) begin
            k = r % NUM_REQ;
            settle();
            checks++; if (grant !== '0) begin errors++; $display("FAIL fair_bubble: round %0d got %b expected 0000", r, grant); end
            tick();
            for (int b = 0; b < MAX_BURST; b++) begin
                settle();
                checks++; if (grant !== NUM_REQ'(1 << k)) begin errors++; $display("FAIL fair_grant: round %0d beat %0d got %b expected %b", r, b, grant, NUM_REQ'(1 << k)); end
                checks++; if (fifo_wr_id !== ID_WIDTH'(k) || fifo_wr_vld !== 1'b1) begin errors++; $display("FAIL fair_id: round %0d got id %0d vld %b expected id %0d vld 1", r, fifo_wr_id, fifo_wr_vld, k); end
                tick();
            end
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        req_vld[2] = 1'b1;
        req_data[2*DW +: DW] = 32'hBEEF_0002;
        tick();
        settle();
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL bp_grant: got %b expected 0100", grant); end
        tick();
        fifo_wr_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            settle();
            checks++; if (busy !== 1'b1 || req_rdy !== '0) begin errors++; $display("FAIL bp_stall: cycle %0d got busy %b rdy %b expected busy 1 rdy 0000", i, busy, req_rdy); end
            checks++; if (fifo_wr_vld !== 1'b1 || fifo_wr_data !== 32'hBEEF_0002) begin errors++; $display("FAIL bp_hold: cycle %0d got vld %b data %h expected vld 1 data beef0002", i, fifo_wr_vld, fifo_wr_data); end
            tick();
        end
        fifo_wr_rdy = 1'b1;
        for (int b = 0; b < MAX_BURST - 1; b++) begin
            settle();
            checks++; if (busy !== 1'b1 || req_rdy !== 4'b0100) begin errors++; $display("FAIL bp_resume: beat %0d got busy %b rdy %b expected busy 1 rdy 0100", b, busy, req_rdy); end
            checks++; if (fifo_wr_data !== 32'hBEEF_0002) begin errors++; $display("FAIL bp_data: got %h expected beef0002", fifo_wr_data); end
            tick();
        end
        settle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release: got busy %b expected 0", busy); end
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        req_vld[0] = 1'b1;
        req_vld[3] = 1'b1;
        tick();
        settle();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL tmo_first: got %b expected 0001", grant); end
        tick();
        req_vld[0] = 1'b0;
        for (int i = 0; i < IDLE_TIMEOUT; i++) begin
            settle();
            checks++; if (busy !== 1'b1 || grant !== 4'b0001) begin errors++; $display("FAIL tmo_hold: idle %0d got busy %b grant %b expected busy 1 grant 0001", i, busy, grant); end
            tick();
        end
        settle();
        checks++; if (busy !== 1'b0 || grant !== '0) begin errors++; $display("FAIL tmo_release: got busy %b grant %b expected busy 0 grant 0000", busy, grant); end
        tick();
        settle();
        checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL tmo_next: got %b expected 1000", grant); end
        clear_inputs();
    endtask

    task automatic test_wrap();
        do_reset();
        req_vld[3]  = 1'b1;
        req_last[3] = 1'b1;
        tick();
        settle();
        checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL wrap_prime: got %b expected 1000", grant); end
        tick();
        clear_inputs();
        req_vld[0]  = 1'b1;
        req_vld[2]  = 1'b1;
        req_last[0] = 1'b1;
        settle();
        checks++; if (grant !== '0) begin errors++; $display("FAIL wrap_bubble: got %b expected 0000", grant); end
        tick();
        settle();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL wrap_grant0: got %b expected 0001", grant); end
        tick();
        settle();
        checks++; if (grant !== '0) begin errors++; $display("FAIL wrap_bubble2: got %b expected 0000", grant); end
        tick();
        settle();
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL wrap_grant2: got %b expected 0100", grant); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_vld[1] = 1'b1;
        req_data[1*DW +: DW] = 32'h1234_5678;
        tick();
        settle();
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL rstmid_grant: got %b expected 0010", grant); end
        tick();
        rst = 1'b1;
        #1;
        checks++; if (grant !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_drop: got grant %b busy %b expected 0000 0", grant, busy); end
        checks++; if (fifo_wr_vld !== 1'b0 || req_rdy !== '0) begin errors++; $display("FAIL rstmid_port: got vld %b rdy %b expected 0 0000", fifo_wr_vld, req_rdy); end
        tick();
        rst = 1'b0;
        req_vld = 4'b0011;
        settle();
        checks++; if (grant !== '0) begin errors++; $display("FAIL rstmid_bubble: got %b expected 0000", grant); end
        tick();
        settle();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rstmid_prio: got %b expected 0001", grant); end
        clear_inputs();
    endtask

    task automatic test_random();
        bit [NUM_REQ-1:0] took;
        int p_vld;
        do_reset();
        m_locked = 1'b0;
        m_g      = 0;
        m_beats  = 0;
        m_idle   = 0;
        m_last   = NUM_REQ - 1;
        took     = '1;
        p_vld    = 50;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 200 == 0) p_vld = (cyc / 200 % 3 == 0) ? 15 : ((cyc / 200 % 3 == 1) ? 50 : 90);
            for (int k = 0; k < NUM_REQ; k++) begin
                // A pending request stays stable until it is taken.
                if (!(req_vld[k] && !took[k])) begin
                    req_vld[k]  = ($urandom_range(0, 99) < p_vld);
                    req_last[k] = ($urandom_range(0, 99) < 30);
                    req_data[k*DW +: DW] = $urandom;
                end
            end
            fifo_wr_rdy = ($urandom_range(0, 99) < 75);
            settle();
            model_eval();
            checks++; if (grant !== exp_grant) begin errors++; $display("FAIL rnd_grant: cycle %0d got %b expected %b", cyc, grant, exp_grant); end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rnd_busy: cycle %0d got %b expected %b", cyc, busy, exp_busy); end
            checks++; if (fifo_wr_vld !== exp_vld) begin errors++; $display("FAIL rnd_vld: cycle %0d got %b expected %b", cyc, fifo_wr_vld, exp_vld); end
            checks++; if (req_rdy !== exp_rdy) begin errors++; $display("FAIL rnd_rdy: cycle %0d got %b expected %b", cyc, req_rdy, exp_rdy); end
            if (exp_vld) begin
                checks++; if (fifo_wr_data !== exp_data || fifo_wr_id !== ID_WIDTH'(m_g)) begin errors++; $display("FAIL rnd_beat: cycle %0d got data %h id %0d expected data %h id %0d", cyc, fifo_wr_data, fifo_wr_id, exp_data, m_g); end
            end
            took = exp_rdy & req_vld;
            model_step();
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_timeout();
        test_wrap();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
